// File: rtl/misc_vpaddr_pkg.sv
// Shared definitions for the MIPS32 virtual-to-physical translation paths:
// segment codes, kseg0 cache attribute, FSM states and the micro-TLB entry layout.
package misc_vpaddr_pkg;

  typedef enum logic [2:0] {
    SEG_USEG  = 3'd0,
    SEG_KSEG0 = 3'd1,
    SEG_KSEG1 = 3'd2,
    SEG_KSEG2 = 3'd3,
    SEG_KSEG3 = 3'd4
  } seg_e;

  localparam logic [2:0] K0_UNCACHED = 3'd2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_MISS = 1'b1
  } state_e;

  // Entry fields are sized for the widest supported configuration; narrower
  // VPN/ASID values are zero-extended on write and compare.
  localparam int VPN_MAX_W  = 32;
  localparam int ASID_MAX_W = 16;

  typedef struct packed {
    logic                  valid;
    logic [VPN_MAX_W-1:0]  vpn;
    logic [ASID_MAX_W-1:0] asid;
    logic                  is_global;
    logic [VPN_MAX_W-1:0]  pfn;
    logic                  uncached;
  } utlb_entry_t;

  function automatic seg_e decode_seg(input logic [2:0] top_bits);
    seg_e s;
    casez (top_bits)
      3'b0??:  s = SEG_USEG;
      3'b100:  s = SEG_KSEG0;
      3'b101:  s = SEG_KSEG1;
      3'b110:  s = SEG_KSEG2;
      default: s = SEG_KSEG3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/misc_vpaddr_utlb_if.sv
// Request/response and main-TLB refill bundle of the micro-TLB translator.
// master is the address-generation/main-TLB side, slave is the translator.
interface misc_vpaddr_utlb_if #(
  parameter int PAGE_SHIFT = 12,
  parameter int ASID_W     = 8
);
  localparam int VPN_W = 32 - PAGE_SHIFT;

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_vaddr;
  logic [ASID_W-1:0] req_asid;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_paddr;
  logic              resp_uncached;
  logic              resp_fault;

  logic              refill_req_valid;
  logic [VPN_W-1:0]  refill_req_vpn;
  logic [ASID_W-1:0] refill_req_asid;
  logic              refill_resp_valid;
  logic              refill_resp_hit;
  logic [VPN_W-1:0]  refill_resp_pfn;
  logic              refill_resp_global;
  logic              refill_resp_uncached;

  modport master (
    output req_valid, req_vaddr, req_asid, resp_ready,
    output refill_resp_valid, refill_resp_hit, refill_resp_pfn,
    output refill_resp_global, refill_resp_uncached,
    input  req_ready, resp_valid, resp_paddr, resp_uncached, resp_fault,
    input  refill_req_valid, refill_req_vpn, refill_req_asid
  );

  modport slave (
    input  req_valid, req_vaddr, req_asid, resp_ready,
    input  refill_resp_valid, refill_resp_hit, refill_resp_pfn,
    input  refill_resp_global, refill_resp_uncached,
    output req_ready, resp_valid, resp_paddr, resp_uncached, resp_fault,
    output refill_req_valid, refill_req_vpn, refill_req_asid
  );

endinterface

// File: rtl/misc_vpaddr_seg.sv
// Combinational MIPS32 segment decoder: classifies the address and produces
// the fixed-offset translation used by the unmapped kseg0/kseg1 windows.
module misc_vpaddr_seg
  import misc_vpaddr_pkg::*;
(
  input  logic [31:0] vaddr,
  input  logic [2:0]  cfg_k0,
  output seg_e        seg,
  output logic        mapped,
  output logic [31:0] paddr,
  output logic        uncached
);

  always_comb begin
    seg      = decode_seg(vaddr[31:29]);
    mapped   = (seg == SEG_USEG) || (seg == SEG_KSEG2) || (seg == SEG_KSEG3);
    paddr    = {3'b000, vaddr[28:0]};
    uncached = (seg == SEG_KSEG1) || ((seg == SEG_KSEG0) && (cfg_k0 == K0_UNCACHED));
  end

endmodule

// File: rtl/misc_vpaddr_utlb.sv
// Sequential address translator: fixed mapping for kseg0/kseg1, fully-associative
// round-robin micro-TLB with a main-TLB refill handshake for mapped segments.
module misc_vpaddr_utlb
  import misc_vpaddr_pkg::*;
#(
  parameter int ENTRIES    = 4,
  parameter int PAGE_SHIFT = 12,
  parameter int ASID_W     = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic [2:0]         cfg_k0,
  misc_vpaddr_utlb_if.slave  bus
);

  localparam int VPN_W = 32 - PAGE_SHIFT;
  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  utlb_entry_t       tlb [ENTRIES];
  logic [PTR_W-1:0]  victim;
  state_e            state, state_next;
  logic [31:0]       miss_vaddr;
  logic [ASID_W-1:0] miss_asid;

  logic              resp_valid, resp_uncached, resp_fault;
  logic [31:0]       resp_paddr;
  logic              refill_req_valid;

  seg_e              seg;
  logic              mapped, seg_uncached;
  logic [31:0]       seg_paddr;

  logic              hit, hit_uncached;
  logic [VPN_W-1:0]  hit_pfn;
  logic              is_unmapped, take_fast, go_miss, accept, req_ready, refill_done;

  misc_vpaddr_seg u_seg (
    .vaddr    (bus.req_vaddr),
    .cfg_k0   (cfg_k0),
    .seg      (seg),
    .mapped   (mapped),
    .paddr    (seg_paddr),
    .uncached (seg_uncached)
  );

  always_comb begin
    hit          = 1'b0;
    hit_pfn      = '0;
    hit_uncached = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!hit && tlb[i].valid
          && tlb[i].vpn == VPN_MAX_W'(bus.req_vaddr[31:PAGE_SHIFT])
          && (tlb[i].is_global || tlb[i].asid == ASID_MAX_W'(bus.req_asid))) begin
        hit          = 1'b1;
        hit_pfn      = tlb[i].pfn[VPN_W-1:0];
        hit_uncached = tlb[i].uncached;
      end
    end
  end

  assign is_unmapped = (seg == SEG_KSEG0) || (seg == SEG_KSEG1);
  assign take_fast   = is_unmapped || (mapped && hit);
  assign go_miss     = mapped && !hit;
  assign req_ready   = (state == ST_RUN) && !flush && (!resp_valid || bus.resp_ready);
  assign accept      = bus.req_valid && req_ready;
  // A refill answer only counts while a miss is outstanding; stray ones in RUN are dropped.
  assign refill_done = (state == ST_MISS) && bus.refill_resp_valid;

  always_comb begin
    state_next       = state;
    refill_req_valid = 1'b0;
    case (state)
      ST_RUN:  if (accept && go_miss) state_next = ST_MISS;
      ST_MISS: begin
        refill_req_valid = 1'b1;
        if (bus.refill_resp_valid) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_RUN;
    else         state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_valid    <= 1'b0;
      resp_paddr    <= '0;
      resp_uncached <= 1'b0;
      resp_fault    <= 1'b0;
      miss_vaddr    <= '0;
      miss_asid     <= '0;
    end else begin
      if (accept && take_fast) begin
        resp_valid    <= 1'b1;
        resp_paddr    <= is_unmapped ? seg_paddr : {hit_pfn, bus.req_vaddr[PAGE_SHIFT-1:0]};
        resp_uncached <= is_unmapped ? seg_uncached : hit_uncached;
        resp_fault    <= 1'b0;
      end else if (refill_done) begin
        resp_valid    <= 1'b1;
        resp_paddr    <= bus.refill_resp_hit ? {bus.refill_resp_pfn, miss_vaddr[PAGE_SHIFT-1:0]}
                                             : miss_vaddr;
        resp_uncached <= bus.refill_resp_hit && bus.refill_resp_uncached;
        resp_fault    <= !bus.refill_resp_hit;
      end else if (bus.resp_ready) begin
        resp_valid <= 1'b0;
      end
      if (accept && go_miss) begin
        miss_vaddr <= bus.req_vaddr;
        miss_asid  <= bus.req_asid;
      end
    end
  end

  // Flush beats a same-edge fill; the pointer only moves when an entry is written.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) tlb[i] <= '0;
      victim <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) tlb[i].valid <= 1'b0;
    end else if (refill_done && bus.refill_resp_hit) begin
      tlb[victim] <= '{valid:     1'b1,
                       vpn:       VPN_MAX_W'(miss_vaddr[31:PAGE_SHIFT]),
                       asid:      ASID_MAX_W'(miss_asid),
                       is_global: bus.refill_resp_global,
                       pfn:       VPN_MAX_W'(bus.refill_resp_pfn),
                       uncached:  bus.refill_resp_uncached};
      victim <= (victim == PTR_W'(ENTRIES - 1)) ? '0 : victim + 1'b1;
    end
  end

  assign bus.req_ready        = req_ready;
  assign bus.resp_valid       = resp_valid;
  assign bus.resp_paddr       = resp_paddr;
  assign bus.resp_uncached    = resp_uncached;
  assign bus.resp_fault       = resp_fault;
  assign bus.refill_req_valid = refill_req_valid;
  assign bus.refill_req_vpn   = miss_vaddr[31:PAGE_SHIFT];
  assign bus.refill_req_asid  = miss_asid;

endmodule
